// File: rtl/ysyx_23060187_mem_responder_pkg.sv
// Shared definitions for the memory responder and its initiators.
package ysyx_23060187_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0]  DEFAULT_BASE  = 32'h8000_0000;
    localparam int unsigned  DEFAULT_DEPTH = 1024;

    // Byte-lane mask width; the LSU uses the same lane encoding.
    localparam int unsigned  MASK_W = 4;

endpackage

// File: rtl/ysyx_23060187_sram_array.sv
// Single-port DEPTH x 32 storage with per-byte write enables and a registered read port.
module ysyx_23060187_sram_array
    import ysyx_23060187_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    input  logic [MASK_W-1:0]        wmask,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Storage and read register carry no reset so their contents survive rst.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < MASK_W; i++) begin
                    if (wmask[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_23060187_mem_responder.sv
// Handshaked fixed-latency memory responder wrapping a word-addressed SRAM.
module ysyx_23060187_mem_responder
    import ysyx_23060187_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        load_q, load_d;

    logic [31:0] offset;
    logic        in_range;
    logic        accept;
    logic [31:0] sram_rdata;

    // Below-BASE addresses wrap to large offsets and fall out of range.
    always_comb begin
        offset   = req_addr - BASE;
        in_range = (offset < SPAN);
        accept   = (state_q == IDLE) && req_valid && !rst;
    end

    // Writes and reads happen at the accepting edge; the read word then sits in the SRAM register.
    ysyx_23060187_sram_array #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (accept && in_range),
        .we    (req_wen),
        .addr  (offset[AW+1:2]),
        .wdata (req_wdata),
        .wmask (req_wmask),
        .rdata (sram_rdata)
    );

    // Next-state, latency countdown and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        load_d     = load_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    err_d  = !in_range;
                    load_d = in_range && !req_wen;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // SRAM register is only consulted for in-range loads, so stores and errors return zero.
    always_comb begin
        resp_rdata = (resp_valid && load_q) ? sram_rdata : '0;
        resp_err   = resp_valid && err_q;
    end

endmodule

// File: tb/tb_ysyx_23060187_mem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 1, 7) against an array memory model.
module tb_ysyx_23060187_mem_responder;

    localparam int          NI    = 3;
    localparam int unsigned LAT [NI] = '{2, 1, 7};
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int          MW    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_wen    [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_wmask  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_23060187_mem_responder #(
            .DEPTH   (DEPTH),
            .BASE    (BASE),
            .LATENCY (LAT[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_wen    (req_wen[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_wmask  (req_wmask[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] mem_m [NI][MW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + longint'(4 * DEPTH);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    // One full transaction: wait ready, accept, measure latency, hold backpressure, handshake.
    task automatic txn(input int k, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int bp, input bit noise, input string tag,
                       output logic [31:0] got_rdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          idx;
        int          n;

        exp_err   = !addr_ok(addr);
        idx       = exp_err ? 0 : int'((addr - BASE) / 4);
        exp_rdata = (!wen && !exp_err) ? mem_m[k][idx] : 32'h0;

        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " ready"}, 32'(req_ready[k]), 32'd1);

        req_valid[k]  = 1'b1;
        req_wen[k]    = wen;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_wmask[k]  = wmask;
        resp_ready[k] = 1'($urandom % 2);
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;

        if (wen && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem_m[k][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end

        if (noise) begin
            req_valid[k] = 1'b1;
            req_wen[k]   = 1'b1;
            req_addr[k]  = BASE + 32'(4 * $urandom_range(0, MW - 1));
            req_wdata[k] = $urandom;
            req_wmask[k] = 4'hF;
        end else begin
            req_valid[k] = 1'b0;
        end

        n = 1;
        while (resp_valid[k] !== 1'b1 && n < 40) begin
            chk({tag, " busy_ready"}, 32'(req_ready[k]), 32'd0);
            @(posedge clk); #1; n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(LAT[k]));
        chk({tag, " rdata"}, resp_rdata[k], exp_rdata);
        chk({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
        got_rdata = resp_rdata[k];

        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, " bp_valid"}, 32'(resp_valid[k]), 32'd1);
            chk({tag, " bp_rdata"}, resp_rdata[k], exp_rdata);
            chk({tag, " bp_err"}, 32'(resp_err[k]), 32'(exp_err));
            chk({tag, " bp_ready"}, 32'(req_ready[k]), 32'd0);
        end

        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        chk({tag, " done_valid"}, 32'(resp_valid[k]), 32'd0);
        chk({tag, " done_ready"}, 32'(req_ready[k]), 32'd1);
    endtask

    // Accept a store, then pulse reset while the responder is still counting down.
    task automatic reset_mid(input int k);
        logic [31:0] rd;
        int n;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        req_valid[k] = 1'b1;
        req_wen[k]   = 1'b1;
        req_addr[k]  = 32'h8000_0004;
        req_wdata[k] = 32'hCAFE_F00D;
        req_wmask[k] = 4'hF;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        mem_m[k][1]  = 32'hCAFE_F00D;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        chk("rst_mid valid", 32'(resp_valid[k]), 32'd0);
        chk("rst_mid ready", 32'(req_ready[k]), 32'd1);
        txn(k, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 1'b0, "rst_mid ld", rd);
        chk("rst_mid committed", rd, 32'hCAFE_F00D);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          k;

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0; resp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("reset req_ready", 32'(req_ready[i]), 32'd1);
            chk("reset resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("reset resp_rdata", resp_rdata[i], 32'd0);
            chk("reset resp_err", 32'(resp_err[i]), 32'd0);
        end

        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < MW; w++) begin
                txn(i, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 0, 1'b0, "init", rd);
            end
        end

        txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, "st10", rd);
        chk("st10 ack_rdata", rd, 32'h0);
        txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, "ld10", rd);
        chk("ld10 value", rd, 32'hDEAD_BEEF);

        txn(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 1'b0, "pre20", rd);
        txn(0, 1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, 0, 1'b0, "mask20", rd);
        txn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, 1'b0, "ld20", rd);
        chk("ld20 value", rd, 32'h1122_AA44);

        txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_CAFE, 4'hF, 0, 1'b0, "pre00", rd);
        txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, "oor_ld", rd);
        chk("oor_ld rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, "oor_st", rd);
        txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, "ld00", rd);
        chk("ld00 untouched", rd, 32'h0BAD_CAFE);

        txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, 1'b1, "bp", rd);
        chk("bp value", rd, 32'hDEAD_BEEF);

        reset_mid(0);
        reset_mid(2);

        for (int it = 0; it < 150; it++) begin
            k = int'($urandom % NI);
            case ($urandom % 8)
                0:       a = BASE - 32'(4 * $urandom_range(1, 8));
                1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
                2:       a = ($urandom % 2 == 0) ? 32'h0 : 32'hFFFF_FFFC;
                default: a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom % 4);
            endcase
            txn(k, 1'($urandom % 2), a, $urandom, 4'($urandom), int'($urandom % 4),
                1'($urandom % 2), "rand", rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
